ff_write_arbiter: RTL and testbench

- Round-robin arbiter that shares one BITS-wide enable-gated D flip-flop register among N requesters.
- Each cycle it picks at most one requesting source and drives the register's enable and data inputs.
- It reports the winner back to the requesters as a one-hot grant.
- It sits directly in front of the shared register; the register's q output is read by everyone and is outside this block.

---
 rtl/ff_write_arbiter.sv | 91 +++++++++
 tb/tb_ff_write_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ff_write_arbiter.sv
// Round-robin arbiter sharing one enable-gated BITS-wide register among N requesters.
// Registered enable/data/grant; hold stalls issue and freezes the rotation pointer.
module ff_write_arbiter #(
   parameter int unsigned BITS = 8,
   parameter int unsigned N    = 4
) (
   input  logic                clk,
   input  logic                reset_L,
   input  logic [N-1:0]        req,
   input  logic [N*BITS-1:0]   data_in,
   input  logic                hold,
   output logic                ff_enb,
   output logic [BITS-1:0]     ff_d,
   output logic [N-1:0]        gnt,
   output logic                busy,
   output logic [15:0]         wr_count
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW-1:0] LAST = PW'(N - 1);

   typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   prio, win, idx, prio_nx;
   logic            found, issue;
   logic [BITS-1:0] win_data;
   logic [N-1:0]    win_onehot;

   // Walk N positions starting at prio, wrapping at N-1; first requester found wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = prio;
      for (int unsigned k = 0; k < N; k++) begin
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
         idx = (idx == LAST) ? '0 : idx + 1'b1;
      end
   end

   always_comb begin
      win_data   = '0;
      win_onehot = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (win == PW'(i)) begin
            win_data = data_in[i*BITS +: BITS];
         end
      end
      win_onehot[win] = 1'b1;
      prio_nx = (win == LAST) ? '0 : win + 1'b1;
   end

   always_comb begin
      state_nx = state;
      issue    = !hold && found;
      case (state)
         IDLE:    if (issue) state_nx = GRANT;
         GRANT:   if (hold) state_nx = STALL;
                  else if (found) state_nx = GRANT;
                  else state_nx = IDLE;
         STALL:   if (!hold) state_nx = found ? GRANT : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state    <= IDLE;
         busy     <= 1'b0;
         prio     <= '0;
         ff_enb   <= 1'b0;
         ff_d     <= '0;
         gnt      <= '0;
         wr_count <= '0;
      end else begin
         state  <= state_nx;
         busy   <= (state_nx == GRANT);
         ff_enb <= issue;
         gnt    <= issue ? win_onehot : '0;
         if (issue) begin
            ff_d     <= win_data;
            prio     <= prio_nx;
            wr_count <= wr_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_ff_write_arbiter.sv
// Directed bench for ff_write_arbiter (BITS=8, N=4): reset, single, contention,
// skip/wrap, hold, mid-run reset and write-counter wrap.
module tb_ff_write_arbiter;

   logic        clk = 1'b0;
   logic        reset_L;
   logic [3:0]  req;
   logic [31:0] data_in;
   logic        hold;
   logic        ff_enb;
   logic [7:0]  ff_d;
   logic [3:0]  gnt;
   logic        busy;
   logic [15:0] wr_count;

   int total = 0;
   int bad   = 0;

   ff_write_arbiter #(.BITS(8), .N(4)) dut (
      .clk      (clk),
      .reset_L  (reset_L),
      .req      (req),
      .data_in  (data_in),
      .hold     (hold),
      .ff_enb   (ff_enb),
      .ff_d     (ff_d),
      .gnt      (gnt),
      .busy     (busy),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   // word0=11, word1=22, word2=A5, word3=44
   localparam logic [31:0] DATA = {8'h44, 8'hA5, 8'h22, 8'h11};

   task automatic do_reset();
      reset_L = 1'b0;
      req     = '0;
      hold    = 1'b0;
      @(posedge clk); #1;
      reset_L = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_L = 1'b0; hold = 1'b0; data_in = DATA; req = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         tick();
         req = ~req;
      end
      req = 4'b1111;
      #1;
      total++; if (ff_enb !== 1'b0)      begin bad++; $display("FAIL reset_enb got=%b exp=0", ff_enb); end
      total++; if (gnt !== 4'b0000)      begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
      total++; if (ff_d !== 8'h00)       begin bad++; $display("FAIL reset_d got=%h exp=00", ff_d); end
      total++; if (wr_count !== 16'd0)   begin bad++; $display("FAIL reset_cnt got=%0d exp=0", wr_count); end
      total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      reset_L = 1'b1;
      tick();
      total++; if (gnt !== 4'b0001)      begin bad++; $display("FAIL first_gnt got=%b exp=0001", gnt); end
      total++; if (ff_d !== 8'h11)       begin bad++; $display("FAIL first_d got=%h exp=11", ff_d); end
      total++; if (busy !== 1'b1)        begin bad++; $display("FAIL first_busy got=%b exp=1", busy); end
      total++; if (wr_count !== 16'd1)   begin bad++; $display("FAIL first_cnt got=%0d exp=1", wr_count); end
   endtask

   task automatic test_single();
      do_reset();
      data_in = DATA; req = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++; if (ff_enb !== 1'b1)  begin bad++; $display("FAIL single_enb[%0d] got=%b exp=1", c, ff_enb); end
         total++; if (ff_d !== 8'hA5)   begin bad++; $display("FAIL single_d[%0d] got=%h exp=a5", c, ff_d); end
         total++; if (gnt !== 4'b0100)  begin bad++; $display("FAIL single_gnt[%0d] got=%b exp=0100", c, gnt); end
      end
      req = 4'b0000;
      tick();
      total++; if (ff_enb !== 1'b0)     begin bad++; $display("FAIL single_off_enb got=%b exp=0", ff_enb); end
      total++; if (gnt !== 4'b0000)     begin bad++; $display("FAIL single_off_gnt got=%b exp=0000", gnt); end
      total++; if (ff_d !== 8'hA5)      begin bad++; $display("FAIL single_hold_d got=%h exp=a5", ff_d); end
      total++; if (wr_count !== 16'd3)  begin bad++; $display("FAIL single_cnt got=%0d exp=3", wr_count); end
      total++; if (busy !== 1'b0)       begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
   endtask

   task automatic test_contention();
      logic [3:0] eg [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      logic [7:0] ed [6] = '{8'h11, 8'h22, 8'hA5, 8'h44, 8'h11, 8'h22};
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 6; c++) begin
         tick();
         total++; if (gnt !== eg[c])   begin bad++; $display("FAIL cont_gnt[%0d] got=%b exp=%b", c, gnt, eg[c]); end
         total++; if (ff_d !== ed[c])  begin bad++; $display("FAIL cont_d[%0d] got=%h exp=%h", c, ff_d, ed[c]); end
      end
      total++; if (wr_count !== 16'd6) begin bad++; $display("FAIL cont_cnt got=%0d exp=6", wr_count); end
   endtask

   task automatic test_skip_wrap();
      logic [3:0] rq [4] = '{4'b0100, 4'b0011, 4'b0011, 4'b1000};
      logic [3:0] eg [4] = '{4'b0100, 4'b0001, 4'b0010, 4'b1000};
      do_reset();
      for (int c = 0; c < 4; c++) begin
         req = rq[c];
         tick();
         total++; if (gnt !== eg[c])   begin bad++; $display("FAIL skip_gnt[%0d] got=%b exp=%b", c, gnt, eg[c]); end
         total++; if (ff_enb !== 1'b1) begin bad++; $display("FAIL skip_enb[%0d] got=%b exp=1", c, ff_enb); end
      end
   endtask

   task automatic test_hold();
      do_reset();
      req = 4'b1111;
      tick();
      tick();
      total++; if (gnt !== 4'b0010)    begin bad++; $display("FAIL hold_pre_gnt got=%b exp=0010", gnt); end
      hold = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         total++; if (ff_enb !== 1'b0) begin bad++; $display("FAIL hold_enb[%0d] got=%b exp=0", c, ff_enb); end
         total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL hold_gnt[%0d] got=%b exp=0000", c, gnt); end
         total++; if (busy !== 1'b0)   begin bad++; $display("FAIL hold_busy[%0d] got=%b exp=0", c, busy); end
         total++; if (ff_d !== 8'h22)  begin bad++; $display("FAIL hold_d[%0d] got=%h exp=22", c, ff_d); end
      end
      total++; if (wr_count !== 16'd2) begin bad++; $display("FAIL hold_cnt got=%0d exp=2", wr_count); end
      hold = 1'b0;
      tick();
      total++; if (gnt !== 4'b0100)    begin bad++; $display("FAIL hold_post_gnt got=%b exp=0100", gnt); end
      total++; if (busy !== 1'b1)      begin bad++; $display("FAIL hold_post_busy got=%b exp=1", busy); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b1111;
      tick();
      tick();
      #2 reset_L = 1'b0;
      #1;
      total++; if (ff_enb !== 1'b0)     begin bad++; $display("FAIL amid_enb got=%b exp=0", ff_enb); end
      total++; if (gnt !== 4'b0000)     begin bad++; $display("FAIL amid_gnt got=%b exp=0000", gnt); end
      total++; if (ff_d !== 8'h00)      begin bad++; $display("FAIL amid_d got=%h exp=00", ff_d); end
      total++; if (wr_count !== 16'd0)  begin bad++; $display("FAIL amid_cnt got=%0d exp=0", wr_count); end
      total++; if (busy !== 1'b0)       begin bad++; $display("FAIL amid_busy got=%b exp=0", busy); end
      #1 reset_L = 1'b1;
      tick();
      total++; if (gnt !== 4'b0001)     begin bad++; $display("FAIL amid_next_gnt got=%b exp=0001", gnt); end
   endtask

   task automatic test_count_wrap();
      do_reset();
      req = 4'b0001;
      for (int c = 0; c < 65535; c++) tick();
      total++; if (wr_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre got=%h exp=ffff", wr_count); end
      tick();
      total++; if (wr_count !== 16'h0000) begin bad++; $display("FAIL wrap_cnt got=%h exp=0000", wr_count); end
      total++; if (gnt !== 4'b0001)       begin bad++; $display("FAIL wrap_gnt got=%b exp=0001", gnt); end
      req = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_skip_wrap();
      test_hold();
      test_reset_mid();
      test_count_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
